// File: rtl/codec_i2c_cfg_seq.sv
// codec_i2c_cfg_seq
// Programs the WM8731 codec over a shared I2C master. After reset, or on
// init_start, it walks an 11-entry init table. Afterwards it forwards single
// software register writes. NACKs are retried a bounded number of times, and a
// transfer that never starts is treated as a failure.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   init_start          pulse, restarts the init table (deferred while busy)
//   sw_req, sw_packet   software write request (level) and 24-bit packet
//   sw_ack, sw_err      one-cycle completion pulse, error flag valid with it
//   i2c_packet, wr_i2c  packet and start pulse to the I2C master
//   i2c_idle            I2C master idle
//   i2c_ack_err         NACK flag, sampled on the cycle i2c_idle rises
//   init_done, init_err sticky init status
//   busy                high in every state except IDLE
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for init_start (or pending restart) or sw_req
// LOAD       | present packet, wait for the master to be idle
// ISSUE      | one-cycle wr_i2c pulse, arm start timeout
// WAIT_START | wait for i2c_idle to fall, or time out
// WAIT_DONE  | wait for i2c_idle to rise, latch NACK
// CHECK      | retry, or record the outcome
// GAP        | idle spacing after a finished packet, then next entry / IDLE
module codec_i2c_cfg_seq #(
  parameter logic [7:0]  DEV_ADDR      = 8'h34,
  parameter int unsigned MAX_RETRY     = 3,
  parameter logic [15:0] GAP_CYCLES    = 16'd500,
  parameter logic [15:0] START_TIMEOUT = 16'd1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        init_start,
  input  logic        sw_req,
  input  logic [23:0] sw_packet,
  output logic        sw_ack,
  output logic        sw_err,
  output logic [23:0] i2c_packet,
  output logic        wr_i2c,
  input  logic        i2c_idle,
  input  logic        i2c_ack_err,
  output logic        init_done,
  output logic        init_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_CHECK,
    S_GAP
  } state_t;

  localparam logic       SRC_INIT  = 1'b0;
  localparam logic       SRC_SW    = 1'b1;
  localparam logic [3:0] LAST_IDX  = 4'd10;
  localparam logic [7:0] RETRY_MAX = 8'(MAX_RETRY);
  // Down-counters run from N-1 to 0, so a count of 0 still costs one cycle.
  localparam logic [15:0] GAP_LOAD = (GAP_CYCLES == 16'd0) ? 16'd0 : GAP_CYCLES - 16'd1;
  localparam logic [15:0] TMO_LOAD = (START_TIMEOUT == 16'd0) ? 16'd0 : START_TIMEOUT - 16'd1;

  state_t      state, next;
  logic [3:0]  idx;
  logic        src;
  logic [7:0]  retry_cnt;
  logic [15:0] tmr;
  logic        fail;
  logic [23:0] sw_pkt;
  logic        init_pend;
  logic        start_init;
  logic        retry_more;

  // {reg[6:0], data[8:0]}
  function automatic logic [15:0] init_entry(input logic [3:0] i);
    case (i)
      4'd0:    init_entry = {7'd15, 9'h000};
      4'd1:    init_entry = {7'd6,  9'h010};
      4'd2:    init_entry = {7'd0,  9'h017};
      4'd3:    init_entry = {7'd1,  9'h017};
      4'd4:    init_entry = {7'd2,  9'h079};
      4'd5:    init_entry = {7'd3,  9'h079};
      4'd6:    init_entry = {7'd4,  9'h012};
      4'd7:    init_entry = {7'd5,  9'h000};
      4'd8:    init_entry = {7'd7,  9'h042};
      4'd9:    init_entry = {7'd8,  9'h000};
      default: init_entry = {7'd9,  9'h001};
    endcase
  endfunction

  assign start_init = init_start | init_pend;
  assign retry_more = fail && (retry_cnt < RETRY_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_LOAD;
    else       state <= next;
  end

  always_comb begin
    next   = state;
    wr_i2c = 1'b0;
    sw_ack = 1'b0;
    sw_err = 1'b0;
    busy   = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start_init || sw_req) next = S_LOAD;
      end
      S_LOAD: begin
        if (i2c_idle) next = S_ISSUE;
      end
      S_ISSUE: begin
        wr_i2c = 1'b1;
        next   = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (!i2c_idle)        next = S_WAIT_DONE;
        else if (tmr == '0)   next = S_CHECK;
      end
      S_WAIT_DONE: begin
        if (i2c_idle) next = S_CHECK;
      end
      S_CHECK: begin
        if (retry_more) begin
          next = S_LOAD;
        end else begin
          next = S_GAP;
          if (src == SRC_SW) begin
            sw_ack = 1'b1;
            sw_err = fail;
          end
        end
      end
      S_GAP: begin
        if (tmr == '0) begin
          if (src == SRC_INIT && idx != LAST_IDX) next = S_LOAD;
          else                                    next = S_IDLE;
        end
      end
      default: next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx        <= '0;
      src        <= SRC_INIT;
      retry_cnt  <= '0;
      tmr        <= '0;
      fail       <= 1'b0;
      sw_pkt     <= '0;
      i2c_packet <= '0;
      init_done  <= 1'b0;
      init_err   <= 1'b0;
      init_pend  <= 1'b0;
    end else begin
      // A restart requested mid-sequence waits for the next return to IDLE.
      if (init_start && state != S_IDLE) init_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (start_init) begin
            idx       <= '0;
            src       <= SRC_INIT;
            retry_cnt <= '0;
            init_done <= 1'b0;
            init_err  <= 1'b0;
            init_pend <= 1'b0;
          end else if (sw_req) begin
            sw_pkt    <= sw_packet;
            src       <= SRC_SW;
            retry_cnt <= '0;
          end
        end
        S_LOAD: begin
          i2c_packet <= (src == SRC_SW) ? sw_pkt : {DEV_ADDR, init_entry(idx)};
        end
        S_ISSUE: begin
          tmr  <= TMO_LOAD;
          fail <= 1'b0;
        end
        S_WAIT_START: begin
          if (i2c_idle) begin
            if (tmr == '0) fail <= 1'b1;
            else           tmr  <= tmr - 16'd1;
          end
        end
        S_WAIT_DONE: begin
          if (i2c_idle) fail <= i2c_ack_err;
        end
        S_CHECK: begin
          if (retry_more) begin
            retry_cnt <= retry_cnt + 8'd1;
          end else begin
            tmr <= GAP_LOAD;
            if (src == SRC_INIT && fail) init_err <= 1'b1;
          end
        end
        S_GAP: begin
          if (tmr == '0) begin
            if (src == SRC_INIT) begin
              if (idx != LAST_IDX) begin
                idx       <= idx + 4'd1;
                retry_cnt <= '0;
              end else if (!init_err) begin
                init_done <= 1'b1;
              end
            end
          end else begin
            tmr <= tmr - 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_codec_i2c_cfg_seq.sv
// Testbench for codec_i2c_cfg_seq: I2C master responder with per-packet NACK
// injection, expected-packet scoreboard, table of software writes and
// hand-written init / reset / arbitration sequences.
module tb_codec_i2c_cfg_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_start;
  logic        sw_req;
  logic [23:0] sw_packet;
  logic        sw_ack;
  logic        sw_err;
  logic [23:0] i2c_packet;
  logic        wr_i2c;
  logic        i2c_idle;
  logic        i2c_ack_err;
  logic        init_done;
  logic        init_err;
  logic        busy;

  codec_i2c_cfg_seq #(
    .DEV_ADDR(8'h34), .MAX_RETRY(3), .GAP_CYCLES(16'd4), .START_TIMEOUT(16'd8)
  ) dut (
    .clk(clk), .reset(reset), .init_start(init_start), .sw_req(sw_req),
    .sw_packet(sw_packet), .sw_ack(sw_ack), .sw_err(sw_err),
    .i2c_packet(i2c_packet), .wr_i2c(wr_i2c), .i2c_idle(i2c_idle),
    .i2c_ack_err(i2c_ack_err), .init_done(init_done), .init_err(init_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [23:0] exp_q[$];
  logic [23:0] init_tbl[11];

  // responder controls / monitor results
  bit          stuck     = 1'b0;
  logic [23:0] nack_pkt  = '0;
  int          nack_left = 0;
  logic [23:0] tgt_pkt   = '0;
  int          tgt_cnt   = 0;
  int          wr_cnt    = 0;
  int          wr_cyc_last = 0;
  int          wr_cyc_prev = 0;
  logic [23:0] first_pkt = '0;
  logic [23:0] last_pkt  = '0;

  typedef struct {
    logic [23:0] pkt;
    int          nacks;
    logic        err;
    int          attempts;
  } sw_vec_t;
  sw_vec_t vecs[4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_init(input int rep_idx, input int reps);
    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(init_tbl[i]);
      if (i == rep_idx)
        for (int r = 1; r < reps; r++) exp_q.push_back(init_tbl[i]);
    end
  endtask

  task automatic clr_stats();
    wr_cnt  = 0;
    tgt_cnt = 0;
  endtask

  task automatic pulse_init();
    init_start = 1'b1;
    @(posedge clk); #1;
    init_start = 1'b0;
  endtask

  task automatic wait_not_busy(input int budget, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_sw_ack(input int budget, output bit got, output logic err,
                             output logic done_at_ack);
    int n = 0;
    got = 1'b0; err = 1'bx; done_at_ack = 1'bx;
    while (!got && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (sw_ack === 1'b1) begin
        got = 1'b1; err = sw_err; done_at_ack = init_done;
        sw_req = 1'b0;
      end
    end
    check("sw_ack_seen", {31'd0, got}, 32'd1);
  endtask

  // I2C master responder and packet monitor
  initial begin : i2c_model
    bit nack_this;
    i2c_idle = 1'b1;
    i2c_ack_err = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (wr_i2c === 1'b1 && reset === 1'b0) begin
        if (wr_cnt == 0) first_pkt = i2c_packet;
        last_pkt = i2c_packet;
        wr_cnt++;
        wr_cyc_prev = wr_cyc_last;
        wr_cyc_last = cyc;
        if (i2c_packet == tgt_pkt) tgt_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sb_unexpected: got packet %h, expected none", i2c_packet);
        end else begin
          check("sb_packet", {8'd0, i2c_packet}, {8'd0, exp_q.pop_front()});
        end
        nack_this = (nack_left > 0) && (i2c_packet == nack_pkt);
        if (nack_this) nack_left--;
        if (!stuck) begin
          i2c_idle = 1'b0;
          repeat (3) @(posedge clk);
          #1;
          i2c_ack_err = nack_this;
          i2c_idle = 1'b1;
          @(posedge clk); #1;
          i2c_ack_err = 1'b0;
        end
      end
    end
  end

  initial begin : main
    bit   got;
    logic err, done_at;
    int   t0;

    init_tbl = '{24'h341E00, 24'h340C10, 24'h340017, 24'h340217, 24'h340479,
                 24'h340679, 24'h340812, 24'h340A00, 24'h340E42, 24'h341000,
                 24'h341201};
    vecs[0] = '{24'h340A1F, 1, 1'b0, 2};
    vecs[1] = '{24'h3412AB, 4, 1'b1, 4};
    vecs[2] = '{24'h3400FF, 3, 1'b0, 4};
    vecs[3] = '{24'h34FE01, 0, 1'b0, 1};

    reset = 1'b1; init_start = 1'b0; sw_req = 1'b0; sw_packet = '0;

    // power-up: reset values, then automatic init
    repeat (3) @(posedge clk);
    #1;
    check("rst_packet",    {8'd0, i2c_packet}, 32'd0);
    check("rst_wr",        {31'd0, wr_i2c},    32'd0);
    check("rst_sw_ack",    {31'd0, sw_ack},    32'd0);
    check("rst_sw_err",    {31'd0, sw_err},    32'd0);
    check("rst_init_done", {31'd0, init_done}, 32'd0);
    check("rst_init_err",  {31'd0, init_err},  32'd0);
    check("rst_busy",      {31'd0, busy},      32'd1);
    clr_stats();
    push_init(-1, 1);
    reset = 1'b0;
    wait_not_busy(3000, "pwr_busy_drop");
    check("pwr_wr_count",  wr_cnt, 11);
    check("pwr_first",     {8'd0, first_pkt}, 32'h00341E00);
    check("pwr_last",      {8'd0, last_pkt},  32'h00341201);
    check("pwr_init_done", {31'd0, init_done}, 32'd1);
    check("pwr_init_err",  {31'd0, init_err},  32'd0);
    check("pwr_drained",   exp_q.size(), 0);

    // R0 NACKed twice, then ACKed
    clr_stats();
    tgt_pkt = 24'h340017; nack_pkt = 24'h340017; nack_left = 2;
    push_init(2, 3);
    pulse_init();
    check("init_start_clears_done", {31'd0, init_done}, 32'd0);
    wait_not_busy(3000, "nack2_busy_drop");
    check("nack2_attempts",  tgt_cnt, 3);
    check("nack2_init_done", {31'd0, init_done}, 32'd1);
    check("nack2_init_err",  {31'd0, init_err},  32'd0);
    check("nack2_drained",   exp_q.size(), 0);

    // R0 NACKed four times: entry exhausted, table continues
    clr_stats();
    nack_left = 4;
    push_init(2, 4);
    pulse_init();
    wait_not_busy(3000, "nack4_busy_drop");
    check("nack4_attempts",  tgt_cnt, 4);
    check("nack4_init_err",  {31'd0, init_err},  32'd1);
    check("nack4_init_done", {31'd0, init_done}, 32'd0);
    check("nack4_wr_count",  wr_cnt, 14);
    check("nack4_drained",   exp_q.size(), 0);

    // i2c_idle stuck high: every attempt times out
    clr_stats();
    stuck = 1'b1;
    for (int i = 0; i < 11; i++)
      for (int r = 0; r < 4; r++) exp_q.push_back(init_tbl[i]);
    pulse_init();
    check("init_start_clears_err", {31'd0, init_err}, 32'd0);
    wait_not_busy(3000, "tmo_busy_drop");
    check("tmo_wr_count",  wr_cnt, 44);
    check("tmo_spacing",   wr_cyc_last - wr_cyc_prev, 11);
    check("tmo_init_err",  {31'd0, init_err},  32'd1);
    check("tmo_init_done", {31'd0, init_done}, 32'd0);
    check("tmo_drained",   exp_q.size(), 0);
    stuck = 1'b0;

    // clean init again, then a software write with latency check
    clr_stats();
    push_init(-1, 1);
    pulse_init();
    wait_not_busy(3000, "reinit_busy_drop");
    check("reinit_init_done", {31'd0, init_done}, 32'd1);
    exp_q.push_back(24'h340C05);
    sw_packet = 24'h340C05; sw_req = 1'b1;
    @(posedge clk); #1;
    check("sw_lat_wr_c1",   {31'd0, wr_i2c}, 32'd0);
    check("sw_lat_busy_c1", {31'd0, busy},   32'd1);
    @(posedge clk); #1;
    check("sw_lat_wr_c2",   {31'd0, wr_i2c}, 32'd1);
    check("sw_lat_packet",  {8'd0, i2c_packet}, 32'h00340C05);
    wait_sw_ack(200, got, err, done_at);
    check("sw_err_ok", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    check("sw_ack_one_cycle", {31'd0, sw_ack}, 32'd0);
    wait_not_busy(100, "sw_busy_drop");
    check("sw_drained", exp_q.size(), 0);

    // table of software writes with NACK injection
    foreach (vecs[v]) begin
      for (int r = 0; r < vecs[v].attempts; r++) exp_q.push_back(vecs[v].pkt);
      tgt_pkt = vecs[v].pkt; tgt_cnt = 0;
      nack_pkt = vecs[v].pkt; nack_left = vecs[v].nacks;
      sw_packet = vecs[v].pkt; sw_req = 1'b1;
      wait_sw_ack(500, got, err, done_at);
      check("vec_sw_err",   {31'd0, err}, {31'd0, vecs[v].err});
      wait_not_busy(100, "vec_busy_drop");
      check("vec_attempts", tgt_cnt, vecs[v].attempts);
      check("vec_drained",  exp_q.size(), 0);
    end
    check("sw_fail_leaves_init_err", {31'd0, init_err}, 32'd0);
    nack_left = 0;

    // sw_req raised during init entry 5: held off until the table finishes
    clr_stats();
    push_init(-1, 1);
    exp_q.push_back(24'h345A5A);
    pulse_init();
    t0 = 0;
    while (wr_cnt < 6 && t0 < 1000) begin
      @(posedge clk); #1;
      t0++;
    end
    check("mid_reached_entry5", {31'd0, (wr_cnt >= 6)}, 32'd1);
    sw_packet = 24'h345A5A; sw_req = 1'b1;
    wait_sw_ack(1500, got, err, done_at);
    check("mid_ack_after_init", {31'd0, done_at}, 32'd1);
    check("mid_sw_err",         {31'd0, err},     32'd0);
    wait_not_busy(100, "mid_busy_drop");
    check("mid_last_pkt", {8'd0, last_pkt}, 32'h00345A5A);
    check("mid_drained",  exp_q.size(), 0);

    // init_start and sw_req in the same IDLE cycle: init wins
    clr_stats();
    push_init(-1, 1);
    exp_q.push_back(24'h340E55);
    sw_packet = 24'h340E55; sw_req = 1'b1;
    pulse_init();
    wait_sw_ack(1500, got, err, done_at);
    check("both_init_first", {31'd0, done_at}, 32'd1);
    check("both_wr_count",   wr_cnt, 12);
    wait_not_busy(100, "both_busy_drop");
    check("both_drained",    exp_q.size(), 0);

    // reset asserted in WAIT_DONE: immediate reset values, table restarts
    clr_stats();
    push_init(-1, 1);
    pulse_init();
    t0 = 0;
    while (wr_i2c !== 1'b1 && t0 < 50) begin
      @(posedge clk); #1;
      t0++;
    end
    check("rstmid_saw_wr", {31'd0, wr_i2c}, 32'd1);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("rstmid_packet", {8'd0, i2c_packet}, 32'd0);
    check("rstmid_busy",   {31'd0, busy},      32'd1);
    check("rstmid_wr",     {31'd0, wr_i2c},    32'd0);
    exp_q.delete();
    clr_stats();
    push_init(-1, 1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    wait_not_busy(3000, "rstmid_busy_drop");
    check("rstmid_first",     {8'd0, first_pkt}, 32'h00341E00);
    check("rstmid_wr_count",  wr_cnt, 11);
    check("rstmid_init_done", {31'd0, init_done}, 32'd1);
    check("rstmid_drained",   exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
